// File: rtl/steer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : steer_pkg
// Brief    : Shared types and phase-sequencing helper for the steering encoder.
// Revision : 1.0
// ============================================================================
package steer_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_t;

  typedef logic [1:0] quad_t;

  // Gray-code walk: RIGHT 00->01->11->10, LEFT the reverse.
  function automatic quad_t quad_next(input quad_t q, input dir_t d);
    quad_t r;
    case (d)
      DIR_RIGHT: r = {q[0], ~q[1]};
      DIR_LEFT:  r = {~q[0], q[1]};
      default:   r = q;
    endcase
    return r;
  endfunction

  function automatic dir_t dir_from_buttons(input logic l, input logic r);
    dir_t d;
    case ({l, r})
      2'b01:   d = DIR_RIGHT;
      2'b10:   d = DIR_LEFT;
      default: d = DIR_IDLE;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/steer_quad_chan.sv
`default_nettype none
// ============================================================================
// Module   : steer_quad_chan
// Brief    : One steering channel: step timer, accelerating period, phase.
//            STEER_ANALOG_EN adds paddle mode and a position counter.
// Revision : 1.0
// ============================================================================
module steer_quad_chan
  import steer_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int ACCEL_SHIFT = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic [DIV_W-1:0] clkdiv_min,
  input  logic             left,
  input  logic             right,
`ifdef STEER_ANALOG_EN
  input  logic             mode,
  input  logic [7:0]       target,
  output logic [7:0]       pos,
`endif
  output logic [1:0]       steer,
  output logic             step
);

  localparam logic [DIV_W-1:0] c_div_one = DIV_W'(1);

  dir_t             dir_q, dir_d, w_dir;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] w_restart_period, w_shrunk, w_accel;
  quad_t            phase_q, phase_d;
  logic             step_q, step_d;
  logic             w_restart;
`ifdef STEER_ANALOG_EN
  logic             mode_q, mode_d;
  logic [7:0]       pos_q, pos_d;
  logic [7:0]       w_diff;
`endif

  always_comb begin
    w_dir            = dir_from_buttons(left, right);
    w_restart_period = clkdiv;
    w_shrunk         = period_q - (period_q >> ACCEL_SHIFT);
    if (ACCEL_SHIFT == 0) begin
      w_accel = period_q;
    end else begin
      w_accel = (w_shrunk < clkdiv_min) ? clkdiv_min : w_shrunk;
    end
    w_restart = 1'b0;
`ifdef STEER_ANALOG_EN
    w_diff = target - pos_q;
    mode_d = mode;
    pos_d  = pos_q;
    if (mode) begin
      // Paddle mode chases the target at the fastest fixed rate.
      w_dir            = (w_diff == 8'd0) ? DIR_IDLE : (w_diff[7] ? DIR_LEFT : DIR_RIGHT);
      w_restart_period = clkdiv_min;
      w_accel          = period_q;
    end
    w_restart = (mode != mode_q);
`endif
    w_restart = w_restart || (w_dir != dir_q);

    dir_d    = w_dir;
    cnt_d    = cnt_q;
    period_d = period_q;
    phase_d  = phase_q;
    step_d   = 1'b0;

    if (w_dir == DIR_IDLE || w_restart) begin
      // A new press (or reversal) always starts from the slow period.
      cnt_d    = '0;
      period_d = w_restart_period;
    end else if (cnt_q >= period_q - c_div_one) begin
      cnt_d    = '0;
      period_d = w_accel;
      phase_d  = quad_next(phase_q, w_dir);
      step_d   = 1'b1;
`ifdef STEER_ANALOG_EN
      pos_d    = (w_dir == DIR_RIGHT) ? pos_q + 8'd1 : pos_q - 8'd1;
`endif
    end else begin
      cnt_d = cnt_q + c_div_one;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      dir_q    <= DIR_IDLE;
      cnt_q    <= '0;
      period_q <= clkdiv;
      phase_q  <= '0;
      step_q   <= 1'b0;
`ifdef STEER_ANALOG_EN
      mode_q   <= 1'b0;
      pos_q    <= '0;
`endif
    end else begin
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
`ifdef STEER_ANALOG_EN
      mode_q   <= mode_d;
      pos_q    <= pos_d;
`endif
    end
  end

  assign steer = phase_q;
  assign step  = step_q;
`ifdef STEER_ANALOG_EN
  assign pos   = pos_q;
`endif

endmodule
`default_nettype wire

// File: rtl/steer_quad_multi.sv
`default_nettype none
// ============================================================================
// Module   : steer_quad_multi
// Brief    : N-channel button-to-quadrature steering encoder with accelerating
//            step rate. STEER_ANALOG_EN adds per-channel paddle mode.
// Revision : 1.0
// ============================================================================
module steer_quad_multi
  import steer_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int ACCEL_SHIFT = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic [DIV_W-1:0]      clkdiv_min,
  input  logic [CHANNELS-1:0]   left,
  input  logic [CHANNELS-1:0]   right,
`ifdef STEER_ANALOG_EN
  input  logic [CHANNELS-1:0]   mode,
  input  logic [8*CHANNELS-1:0] target,
  output logic [8*CHANNELS-1:0] pos,
`endif
  output logic [2*CHANNELS-1:0] steer,
  output logic [CHANNELS-1:0]   step
);

  logic [DIV_W-1:0] w_div, w_min_raw, w_div_min;

  // Zero periods would never fire, and a minimum above the start would slow down.
  always_comb begin
    w_div     = (clkdiv == '0) ? DIV_W'(1) : clkdiv;
    w_min_raw = (clkdiv_min == '0) ? DIV_W'(1) : clkdiv_min;
    w_div_min = (w_min_raw > w_div) ? w_div : w_min_raw;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    steer_quad_chan #(
      .DIV_W       (DIV_W),
      .ACCEL_SHIFT (ACCEL_SHIFT)
    ) u_chan (
      .CLK        (CLK),
      .RESET      (RESET),
      .clkdiv     (w_div),
      .clkdiv_min (w_div_min),
      .left       (left[c]),
      .right      (right[c]),
`ifdef STEER_ANALOG_EN
      .mode       (mode[c]),
      .target     (target[8*c +: 8]),
      .pos        (pos[8*c +: 8]),
`endif
      .steer      (steer[2*c +: 2]),
      .step       (step[c])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_steer_quad_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_steer_quad_multi
// Brief    : Scoreboard bench for steer_quad_multi (2 channels, ACCEL_SHIFT=2).
// Revision : 1.0
// ============================================================================
module tb_steer_quad_multi;

  typedef struct packed {
    int         cyc;
    int         ch;
    logic [1:0] st;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] clkdiv, clkdiv_min;
  logic [1:0]  left, right;
  logic [3:0]  steer;
  logic [1:0]  step;
`ifdef STEER_ANALOG_EN
  logic [1:0]  mode;
  logic [15:0] target;
  logic [15:0] pos;
`endif

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [1:0] ring [4];
  int   idx [2];

  steer_quad_multi #(.CHANNELS(2), .DIV_W(16), .ACCEL_SHIFT(2)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .clkdiv     (clkdiv),
    .clkdiv_min (clkdiv_min),
    .left       (left),
    .right      (right),
`ifdef STEER_ANALOG_EN
    .mode       (mode),
    .target     (target),
    .pos        (pos),
`endif
    .steer      (steer),
    .step       (step)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard monitor: every step pulse must match the oldest expectation.
  always @(posedge CLK) begin
    #1;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL step_missing ch=%0d want cyc=%0d steer=%b, not observed by cyc=%0d", mon_e.ch, mon_e.cyc, mon_e.st, cyc);
    end
    for (int c = 0; c < 2; c++) begin
      if (step[c] !== 1'b0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL step_unexpected ch=%0d cyc=%0d got steer=%b want no step", c, cyc, steer[2*c +: 2]);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.ch != c || mon_e.cyc != cyc || steer[2*c +: 2] !== mon_e.st) begin
            errors++;
            $display("FAIL step_sb got ch=%0d cyc=%0d steer=%b want ch=%0d cyc=%0d steer=%b",
                     c, cyc, steer[2*c +: 2], mon_e.ch, mon_e.cyc, mon_e.st);
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_to(input int at);
    int guard = 0;
    while (cyc < at && guard < 5000) begin
      sync();
      guard++;
    end
  endtask

  task automatic push_exp(input int ch, input int at, input bit rightward);
    exp_t e;
    idx[ch]  = rightward ? (idx[ch] + 1) % 4 : (idx[ch] + 3) % 4;
    e.cyc    = at;
    e.ch     = ch;
    e.st     = ring[idx[ch]];
    sb.push_back(e);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    right = 2'b11;
    repeat (3) sync();
    checks++;
    if (steer !== 4'b0000) begin errors++; $display("FAIL reset_steer got %b want 0000", steer); end
    checks++;
    if (step !== 2'b00) begin errors++; $display("FAIL reset_step got %b want 00", step); end
    RESET = 1'b0;
    right = 2'b00;
    repeat (2) sync();
    checks++;
    if (steer !== 4'b0000) begin errors++; $display("FAIL post_reset_steer got %b want 0000", steer); end
  endtask

  task automatic test_constant_rate();
    int n;
    clkdiv = 16'd4; clkdiv_min = 16'd4;
    right = 2'b01;
    n = cyc + 1;
    for (int k = 1; k <= 4; k++) push_exp(0, n + 4 * k, 1'b1);
    wait_to(n + 16);
    right = 2'b00;
    wait_to(n + 22);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL t1_pending got %0d want 0", sb.size()); end
    checks++;
    if (steer[1:0] !== 2'b00) begin errors++; $display("FAIL t1_final got %b want 00", steer[1:0]); end
  endtask

  task automatic test_accel();
    int n, p, at;
    clkdiv = 16'd16; clkdiv_min = 16'd8;
    left = 2'b10;
    n = cyc + 1;
    p = 16; at = n;
    for (int k = 0; k < 5; k++) begin
      at = at + p;
      push_exp(1, at, 1'b0);
      p = p - p / 4;
      if (p < 8) p = 8;
    end
    wait_to(at);
    left = 2'b00;
    wait_to(at + 12);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL t2_pending got %0d want 0", sb.size()); end
    checks++;
    if (steer[3:2] !== ring[idx[1]]) begin errors++; $display("FAIL t2_final got %b want %b", steer[3:2], ring[idx[1]]); end
  endtask

  task automatic test_both_pressed();
    int n;
    clkdiv = 16'd16; clkdiv_min = 16'd16;
    left = 2'b01; right = 2'b01;
    wait_to(cyc + 50);
    checks++;
    if (steer[1:0] !== ring[idx[0]]) begin errors++; $display("FAIL t3_hold got %b want %b", steer[1:0], ring[idx[0]]); end
    right = 2'b00;
    n = cyc + 1;
    push_exp(0, n + 16, 1'b0);
    wait_to(n + 16);
    left = 2'b00;
    wait_to(n + 20);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL t3_pending got %0d want 0", sb.size()); end
  endtask

  task automatic test_reversal_reset();
    int n, r;
    clkdiv = 16'd8; clkdiv_min = 16'd8;
    right = 2'b01;
    n = cyc + 1;
    push_exp(0, n + 8, 1'b1);
    push_exp(0, n + 16, 1'b1);
    wait_to(n + 19);
    right = 2'b00; left = 2'b01;
    r = n + 20;
    push_exp(0, r + 8, 1'b0);
    push_exp(0, r + 16, 1'b0);
    wait_to(r + 23);
    checks++;
    if (steer[1:0] !== 2'b10) begin errors++; $display("FAIL t4_before_reset got %b want 10", steer[1:0]); end
    // Reset lands on the edge where the next step would fire.
    RESET = 1'b1;
    sync();
    checks++;
    if (step !== 2'b00) begin errors++; $display("FAIL t4_reset_step got %b want 00", step); end
    checks++;
    if (steer !== 4'b0000) begin errors++; $display("FAIL t4_reset_steer got %b want 0000", steer); end
    idx[0] = 0; idx[1] = 0;
    RESET = 1'b0; left = 2'b00;
    repeat (10) sync();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL t4_pending got %0d want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int n, p, at;
    clkdiv = 16'd6; clkdiv_min = 16'd3;
    right = 2'b11;
    n = cyc + 1;
    p = 6; at = n;
    for (int k = 0; k < 5; k++) begin
      at = at + p;
      push_exp(0, at, 1'b1);
      push_exp(1, at, 1'b1);
      p = p - p / 4;
      if (p < 3) p = 3;
    end
    wait_to(at);
    right = 2'b00;
    wait_to(at + 8);
    checks++;
    if (steer[1:0] !== steer[3:2] || steer[1:0] !== ring[idx[0]]) begin
      errors++; $display("FAIL t5_match got %b want %b%b", steer, ring[idx[1]], ring[idx[0]]);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL t5_pending got %0d want 0", sb.size()); end
  endtask

  task automatic test_clamp();
    int n;
    clkdiv = 16'd0; clkdiv_min = 16'd0;
    right = 2'b01;
    n = cyc + 1;
    for (int k = 1; k <= 4; k++) push_exp(0, n + k, 1'b1);
    wait_to(n + 4);
    right = 2'b00;
    wait_to(n + 8);
    clkdiv = 16'd5; clkdiv_min = 16'd9;
    left = 2'b10;
    n = cyc + 1;
    for (int k = 1; k <= 3; k++) push_exp(1, n + 5 * k, 1'b0);
    wait_to(n + 15);
    left = 2'b00;
    wait_to(n + 22);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL clamp_pending got %0d want 0", sb.size()); end
    checks++;
    if (steer !== {ring[idx[1]], ring[idx[0]]}) begin
      errors++; $display("FAIL clamp_final got %b want %b%b", steer, ring[idx[1]], ring[idx[0]]);
    end
  endtask

`ifdef STEER_ANALOG_EN
  task automatic test_analog();
    int n, at;
    RESET = 1'b1;
    sync();
    RESET = 1'b0;
    idx[0] = 0; idx[1] = 0;
    clkdiv = 16'd2; clkdiv_min = 16'd2;
    target = {8'd0, 8'd3};
    mode = 2'b01;
    n = cyc + 1;
    for (int k = 1; k <= 3; k++) push_exp(0, n + 2 * k, 1'b1);
    wait_to(n + 12);
    checks++;
    if (pos[7:0] !== 8'd3) begin errors++; $display("FAIL t6_pos_up got %0d want 3", pos[7:0]); end
    target = {8'd0, 8'h83};
    n = cyc + 1;
    at = n;
    for (int k = 0; k < 128; k++) begin
      at = at + 2;
      push_exp(0, at, 1'b0);
    end
    wait_to(at + 10);
    checks++;
    if (pos[7:0] !== 8'h83) begin errors++; $display("FAIL t6_pos_down got %h want 83", pos[7:0]); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL t6_pending got %0d want 0", sb.size()); end
    mode = 2'b00;
  endtask
`endif

  initial begin
    ring[0] = 2'b00; ring[1] = 2'b01; ring[2] = 2'b11; ring[3] = 2'b10;
    idx[0] = 0; idx[1] = 0;
    RESET = 1'b1;
    left = 2'b00; right = 2'b00;
    clkdiv = 16'd4; clkdiv_min = 16'd4;
`ifdef STEER_ANALOG_EN
    mode = 2'b00; target = 16'd0;
`endif
    test_reset();
    test_constant_rate();
    test_accel();
    test_both_pressed();
    test_reversal_reset();
    test_back_to_back();
    test_clamp();
`ifdef STEER_ANALOG_EN
    test_analog();
`endif
    repeat (2) sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
